// File: rtl/poly_tone_synth.sv
// poly_tone_synth: polyphonic square-wave tone generator.
// Up to VOICES voices are allocated from a fixed 16-note table by decoded key
// events. The voice tones are summed and turned into a 1-bit speaker stream by
// a first-order sigma-delta modulator. Voice status is reported for LEDs and
// the seven-segment display.
//
// Event interface: key_valid is a one-cycle strobe with no ready signal. The
// block accepts every event on the edge where key_valid is high, and
// key_make/key_note are sampled only on that edge.
module poly_tone_synth #(
  parameter int CLK_HZ = 100_000_000,
  parameter int VOICES = 4,
  parameter int CNT_W  = 20
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              key_valid,
  input  logic              key_make,
  input  logic [3:0]        key_note,
  output logic              speaker,
  output logic [VOICES-1:0] active_mask,
  output logic [3:0]        voice_count,
  output logic              steal
);

  localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  // Accumulator stays below VOICES (<= 8) and the tone sum is <= VOICES, so
  // acc + sum is at most 15 and fits in 4 bits.
  localparam int ACC_W = 4;

  // Note frequencies in Hz, C4 .. E5.
  function automatic int note_hz(input int n);
    case (n)
      0:       return 262;
      1:       return 277;
      2:       return 294;
      3:       return 311;
      4:       return 330;
      5:       return 349;
      6:       return 370;
      7:       return 392;
      8:       return 415;
      9:       return 440;
      10:      return 466;
      11:      return 494;
      12:      return 523;
      13:      return 554;
      14:      return 587;
      default: return 659;
    endcase
  endfunction

  // Terminal counter values (half period minus one), built at elaboration so
  // no divider exists in hardware.
  function automatic logic [16*CNT_W-1:0] build_half_m1();
    logic [16*CNT_W-1:0] tbl;
    int                  h;
    tbl = '0;
    for (int n = 0; n < 16; n++) begin
      h = CLK_HZ / (2 * note_hz(n));
      if (h < 1) h = 1;
      tbl[n*CNT_W +: CNT_W] = CNT_W'(h - 1);
    end
    return tbl;
  endfunction

  localparam logic [16*CNT_W-1:0] HALF_M1 = build_half_m1();

  logic [CNT_W-1:0]  half_m1_tbl [16];
  logic [VOICES-1:0] v_valid;
  logic [3:0]        v_note [VOICES];
  logic [CNT_W-1:0]  v_cnt  [VOICES];
  logic [VOICES-1:0] v_tone;
  logic [PTR_W-1:0]  steal_ptr;
  logic [ACC_W-1:0]  acc;

  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              free_any;
  logic [PTR_W-1:0]  free_idx;
  logic              load_en;
  logic [PTR_W-1:0]  load_idx;
  logic              clear_en;
  logic              steal_now;
  logic [ACC_W-1:0]  tone_sum;
  logic [ACC_W-1:0]  mix_t;
  logic [3:0]        valid_cnt;

  for (genvar n = 0; n < 16; n++) begin : g_tbl
    assign half_m1_tbl[n] = HALF_M1[n*CNT_W +: CNT_W];
  end

  // Find the voice holding key_note and the lowest-index free voice.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (v_valid[v] && (v_note[v] == key_note)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(v);
      end
    end
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (!v_valid[v]) begin
        free_any = 1'b1;
        free_idx = PTR_W'(v);
      end
    end
  end

  // Resolve the event: retrigger is ignored, else free voice, else steal.
  always_comb begin
    load_en   = 1'b0;
    load_idx  = free_idx;
    clear_en  = 1'b0;
    steal_now = 1'b0;
    if (key_valid) begin
      if (key_make) begin
        if (!hit) begin
          load_en = 1'b1;
          if (!free_any) begin
            load_idx  = steal_ptr;
            steal_now = 1'b1;
          end
        end
      end else if (hit) begin
        clear_en = 1'b1;
      end
    end
  end

  // Voice state: an event on a voice takes precedence over its counting.
  always_ff @(posedge CLK) begin
    for (int v = 0; v < VOICES; v++) begin
      if (rst) begin
        v_valid[v] <= 1'b0;
        v_note[v]  <= '0;
        v_cnt[v]   <= '0;
        v_tone[v]  <= 1'b0;
      end else if (load_en && (load_idx == PTR_W'(v))) begin
        v_valid[v] <= 1'b1;
        v_note[v]  <= key_note;
        v_cnt[v]   <= '0;
        v_tone[v]  <= 1'b0;
      end else if (clear_en && (hit_idx == PTR_W'(v))) begin
        v_valid[v] <= 1'b0;
        v_cnt[v]   <= '0;
        v_tone[v]  <= 1'b0;
      end else if (v_valid[v]) begin
        if (v_cnt[v] == half_m1_tbl[v_note[v]]) begin
          v_cnt[v]  <= '0;
          v_tone[v] <= ~v_tone[v];
        end else begin
          v_cnt[v] <= v_cnt[v] + 1'b1;
        end
      end
    end
  end

  // Round-robin steal pointer and one-cycle steal pulse.
  always_ff @(posedge CLK) begin
    if (rst) begin
      steal_ptr <= '0;
      steal     <= 1'b0;
    end else begin
      steal <= steal_now;
      if (steal_now) begin
        steal_ptr <= (steal_ptr == PTR_W'(VOICES - 1)) ? '0 : steal_ptr + 1'b1;
      end
    end
  end

  // Popcounts of the tone bits (mixer input) and of the active voices.
  always_comb begin
    tone_sum  = '0;
    valid_cnt = '0;
    for (int v = 0; v < VOICES; v++) begin
      tone_sum  = tone_sum + ACC_W'(v_tone[v]);
      valid_cnt = valid_cnt + 4'(v_valid[v]);
    end
    mix_t = acc + tone_sum;
  end

  // First-order sigma-delta: emit a 1 whenever the accumulator crosses VOICES.
  always_ff @(posedge CLK) begin
    if (rst) begin
      acc     <= '0;
      speaker <= 1'b0;
    end else if (mix_t >= ACC_W'(VOICES)) begin
      acc     <= mix_t - ACC_W'(VOICES);
      speaker <= 1'b1;
    end else begin
      acc     <= mix_t;
      speaker <= 1'b0;
    end
  end

  assign active_mask = v_valid;
  assign voice_count = valid_cnt;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Testbench for poly_tone_synth: directed key events, a cycle model feeding an
// expected-output queue, and targeted checks of allocation, stealing, timing.
module tb_poly_tone_synth;

  localparam int CLK_HZ = 88000;
  localparam int NV     = 4;
  localparam int CNT_W  = 20;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          rst;
  logic          key_valid;
  logic          key_make;
  logic [3:0]    key_note;
  logic          speaker;
  logic [NV-1:0] active_mask;
  logic [3:0]    voice_count;
  logic          steal;

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int fails     = 0;

  logic [9:0] exp_q[$];

  poly_tone_synth #(
    .CLK_HZ(CLK_HZ),
    .VOICES(NV),
    .CNT_W (CNT_W)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_make   (key_make),
    .key_note   (key_note),
    .speaker    (speaker),
    .active_mask(active_mask),
    .voice_count(voice_count),
    .steal      (steal)
  );

  // ---------------- reference model ----------------
  int   freq [16] = '{262, 277, 294, 311, 330, 349, 370, 392,
                      415, 440, 466, 494, 523, 554, 587, 659};
  int   m_valid [NV];
  int   m_note  [NV];
  int   m_cnt   [NV];
  int   m_tone  [NV];
  int   m_acc;
  int   m_ptr;
  logic m_spk;
  logic m_steal;

  always @(posedge CLK) begin : model
    int         sum;
    int         t;
    int         hit;
    int         fr;
    int         half;
    int         cnt;
    logic [3:0] mk;
    if (rst) begin
      for (int v = 0; v < NV; v++) begin
        m_valid[v] = 0; m_note[v] = 0; m_cnt[v] = 0; m_tone[v] = 0;
      end
      m_acc = 0; m_ptr = 0; m_spk = 1'b0; m_steal = 1'b0;
    end else begin
      sum = 0;
      for (int v = 0; v < NV; v++) sum += m_tone[v];
      t = m_acc + sum;
      if (t >= NV) begin m_spk = 1'b1; m_acc = t - NV; end
      else begin m_spk = 1'b0; m_acc = t; end
      for (int v = 0; v < NV; v++) begin
        if (m_valid[v] != 0) begin
          half = CLK_HZ / (2 * freq[m_note[v]]);
          if (half < 1) half = 1;
          if (m_cnt[v] == half - 1) begin m_cnt[v] = 0; m_tone[v] = 1 - m_tone[v]; end
          else m_cnt[v] = m_cnt[v] + 1;
        end
      end
      m_steal = 1'b0;
      if (key_valid) begin
        hit = -1;
        for (int v = 0; v < NV; v++)
          if (m_valid[v] != 0 && m_note[v] == int'(key_note)) hit = v;
        if (key_make) begin
          if (hit < 0) begin
            fr = -1;
            for (int v = NV - 1; v >= 0; v--) if (m_valid[v] == 0) fr = v;
            if (fr < 0) begin
              fr = m_ptr; m_steal = 1'b1; m_ptr = (m_ptr + 1) % NV;
            end
            m_valid[fr] = 1; m_note[fr] = int'(key_note); m_cnt[fr] = 0; m_tone[fr] = 0;
          end
        end else if (hit >= 0) begin
          m_valid[hit] = 0; m_cnt[hit] = 0; m_tone[hit] = 0;
        end
      end
    end
    mk = '0; cnt = 0;
    for (int v = 0; v < NV; v++) if (m_valid[v] != 0) begin mk[v] = 1'b1; cnt++; end
    exp_q.push_back({m_spk, m_steal, mk, 4'(cnt)});
  end

  // ---------------- scoreboard ----------------
  always @(negedge CLK) begin : scoreboard
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      assert ({speaker, steal, active_mask, voice_count} === e) else begin
        fails++;
        $error("FAIL sb @%0t: got spk/steal/mask/cnt=%b expected %b", $time,
               {speaker, steal, active_mask, voice_count}, e);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic make, input logic [3:0] note);
    key_valid = 1'b1; key_make = make; key_note = note;
    @(posedge CLK);
    #1;
    key_valid = 1'b0; key_make = 1'b0; key_note = 4'd0;
    @(negedge CLK);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int hi;
    int first;
    rst = 1'b1; key_valid = 1'b0; key_make = 1'b0; key_note = 4'd0;
    cycles(3);
    check("rst_speaker", 32'(speaker), 32'd0);
    check("rst_mask", 32'(active_mask), 32'd0);
    check("rst_count", 32'(voice_count), 32'd0);
    check("rst_steal", 32'(steal), 32'd0);
    rst = 1'b0;
    cycles(1);

    // Single voice A4: half period 100 cycles, density 1/4 while high.
    send(1'b1, 4'd9);
    check("a4_mask", 32'(active_mask), 32'h1);
    check("a4_count", 32'(voice_count), 32'd1);
    hi = 0; first = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge CLK);
      if (speaker) begin
        hi++;
        if (first < 0) first = i;
      end
    end
    check("a4_first_pulse", 32'(first), 32'd104);
    check("a4_pulses_2_periods", 32'(hi), 32'd50);

    // Fill all four voices, retrigger ignored.
    do_reset();
    send(1'b1, 4'd0); send(1'b1, 4'd4); send(1'b1, 4'd7); send(1'b1, 4'd12);
    check("fill_mask", 32'(active_mask), 32'hf);
    check("fill_count", 32'(voice_count), 32'd4);
    check("fill_steal", 32'(steal), 32'd0);
    send(1'b1, 4'd4);
    check("retrig_mask", 32'(active_mask), 32'hf);
    check("retrig_steal", 32'(steal), 32'd0);

    // Stealing: 15 evicts voice 0 (note 0), 14 evicts voice 1 (note 4).
    send(1'b1, 4'd15);
    check("steal1_pulse", 32'(steal), 32'd1);
    check("steal1_mask", 32'(active_mask), 32'hf);
    cycles(1);
    check("steal1_drop", 32'(steal), 32'd0);
    send(1'b1, 4'd14);
    check("steal2_pulse", 32'(steal), 32'd1);
    send(1'b0, 4'd4);
    check("evicted_release", 32'(active_mask), 32'hf);

    // Release and reuse of the lowest free voice.
    send(1'b0, 4'd7);
    check("rel7_mask", 32'(active_mask), 32'hb);
    check("rel7_count", 32'(voice_count), 32'd3);
    send(1'b1, 4'd3);
    check("reuse_mask", 32'(active_mask), 32'hf);
    check("reuse_steal", 32'(steal), 32'd0);
    send(1'b0, 4'd11);
    check("unheld_release", 32'(active_mask), 32'hf);
    send(1'b0, 4'd3);
    check("rel3_mask", 32'(active_mask), 32'hb);
    send(1'b0, 4'd14);
    check("rel14_mask", 32'(active_mask), 32'h9);
    send(1'b0, 4'd15);
    check("rel15_mask", 32'(active_mask), 32'h8);
    send(1'b0, 4'd12);
    check("rel12_mask", 32'(active_mask), 32'h0);
    check("rel12_count", 32'(voice_count), 32'd0);

    // All four tones high together: speaker solid 1.
    send(1'b1, 4'd15); send(1'b1, 4'd14); send(1'b1, 4'd13); send(1'b1, 4'd12);
    cycles(87);
    hi = 0;
    for (int i = 0; i < 41; i++) begin
      if (speaker) hi++;
      @(negedge CLK);
    end
    check("all_high_run", 32'(hi), 32'd41);
    send(1'b0, 4'd15); send(1'b0, 4'd14); send(1'b0, 4'd13); send(1'b0, 4'd12);
    cycles(1);
    check("silent_speaker", 32'(speaker), 32'd0);
    check("silent_mask", 32'(active_mask), 32'h0);

    // Reset mid-tone with a coincident press.
    send(1'b1, 4'd9);
    cycles(150);
    rst = 1'b1; key_valid = 1'b1; key_make = 1'b1; key_note = 4'd3;
    @(posedge CLK);
    #1;
    key_valid = 1'b0; key_make = 1'b0; key_note = 4'd0;
    @(negedge CLK);
    check("rst_mid_speaker", 32'(speaker), 32'd0);
    check("rst_mid_mask", 32'(active_mask), 32'h0);
    check("rst_mid_count", 32'(voice_count), 32'd0);
    check("rst_mid_steal", 32'(steal), 32'd0);
    rst = 1'b0;
    cycles(5);
    check("post_rst_mask", 32'(active_mask), 32'h0);
    check("post_rst_speaker", 32'(speaker), 32'd0);

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/poly_tone_synth.md
Name: poly_tone_synth

Overview:
- Parametrised, polyphonic successor to the single-voice piano tone generator.
- Accepts decoded key press/release events (note index plus make/break) from the keyboard front end.
- Allocates up to VOICES simultaneous square-wave voices from a fixed 16-note table.
- Mixes the voices with a first-order sigma-delta modulator onto the 1-bit speaker pin; also reports voice status for LED and seven-segment display.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz; used to derive half-period counts at elaboration.
VOICES, 4, number of simultaneous voices (1..8).
CNT_W, 20, width of each voice half-period counter; must hold the largest half-period count.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
key_valid  input  1  one-cycle event strobe; at most one event per cycle.
key_make  input  1  sampled with key_valid: 1 = press, 0 = release.
key_note  input  4  note index 0..15, sampled with key_valid.
speaker  output  1  registered sigma-delta audio bit.
active_mask  output  VOICES  bit v = 1 when voice v holds a note.
voice_count  output  4  number of active voices (popcount of active_mask).
steal  output  1  one-cycle pulse when a press evicted a held voice.

Behaviour:
- Note table. Indices 0..15 map to C4 262, C#4 277, D4 294, D#4 311, E4 330, F4 349, F#4 370, G4 392, G#4 415, A4 440, A#4 466, B4 494, C5 523, C#5 554, D5 587, E5 659 (Hz).
  - half[n] = floor(CLK_HZ / (2*f[n])), minimum 1.
  - Computed as elaboration-time constants; no runtime divider.
- Per-voice state: valid, note (4b), counter (CNT_W), tone bit.
- Active voice timing:
  - If counter == half[note]-1, the counter clears and the tone bit toggles; otherwise the counter increments.
  - Resulting period is exactly 2*half cycles.
  - An idle voice holds counter = 0 and tone = 0.
- Press (key_valid & key_make), resolved in priority order:
  1. Note already held by some voice: no change, no steal.
  2. Otherwise, lowest-index free voice: set valid, load note, counter = 0, tone = 0.
  3. No voice free: overwrite the voice at steal_ptr (reloaded as in case 2), pulse steal, and set steal_ptr = (steal_ptr+1) mod VOICES.
- Release (key_valid & ~key_make):
  - The voice holding key_note clears valid, counter and tone.
  - Release of an unheld note is ignored.
- Timing: the event is sampled at edge k. active_mask, voice_count and steal reflect it after edge k; the voice counts from the following cycle.
- Mixer:
  - sum = number of voices with tone = 1 (0..VOICES).
  - Each cycle, t = acc + sum.
  - If t >= VOICES: speaker <= 1 and acc <= t - VOICES.
  - Else: speaker <= 0 and acc <= t.
  - One-cycle registered latency. Pulse density equals sum/VOICES.
  - With no voices active, sum = 0, so speaker stays 0.
- Reset (synchronous):
  - All voices are cleared; acc = 0, steal_ptr = 0.
  - speaker = 0, active_mask = 0, voice_count = 0, steal = 0.
  - Reset overrides a coincident key_valid.
  - Reset mid-tone silences the output from the next cycle.
- key_note is always in range (4 bits). No X propagation: all state is reset.

Test Plan:
1. CLK_HZ=88000, VOICES=4. Reset, then press note 9 (A4, half = 100) → active_mask=0001, voice_count=1. Tone of voice 0 toggles every 100 cycles, period 200. Speaker density 1/4 while the tone is high, 0 while it is low.
2. Press notes 0, 4, 7, 12 in successive cycles → active_mask=1111, voice_count=4, no steal. Press 4 again → no change.
3. With 4 voices held, press note 15 → steal pulses for 1 cycle and voice 0 holds note 15 (steal_ptr=0 → 1). Press note 14 → voice 1 is overwritten.
4. Release note 7 (voice 2) → active_mask bit 2 clears next cycle. Press note 3 → it reuses voice 2 (lowest free), with no steal. Release unheld note 11 → no change.
5. All voices held with tones forced high by timing → speaker constantly 1. Release all → speaker 0 within 1 cycle after the last tone drops.
6. Assert rst mid-tone together with a key_valid press → all outputs 0 on the next edge, and the press is ignored.
